// File: rtl/uart_ram_arbiter_pkg.sv
// Shared constants for the UART/second-master RAM arbiter: owner encodings,
// default burst window and a small helper mapping a requester index to its owner code.
package uart_ram_arbiter_pkg;

    localparam logic [1:0] ARB_IDLE = 2'd0;
    localparam logic [1:0] ARB_OWN0 = 2'd1;
    localparam logic [1:0] ARB_OWN1 = 2'd2;

    localparam int DEF_MAX_BURST = 4;

    // Owner code for requester index (0 -> OWN0, 1 -> OWN1)
    function automatic logic [1:0] arb_own_of(input logic idx);
        if (idx) begin
            return ARB_OWN1;
        end else begin
            return ARB_OWN0;
        end
    endfunction

endpackage

// File: rtl/uart_ram_arbiter_if.sv
// Requester-side access port of the RAM arbiter: request/command towards the
// arbiter, grant and registered read return back to the requester.
interface uart_ram_arbiter_if #(
    parameter int AW = 8,
    parameter int DW = 8
);
    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          gnt;
    logic          rvalid;
    logic [DW-1:0] rdata;

    modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/uart_ram_arbiter_rd_capture.sv
// Per-requester read-return register: captures the RAM's combinational read
// data on the edge that ends a granted read and flags it valid for one cycle.
module uart_ram_arbiter_rd_capture #(
    parameter int DW = 8
) (
    input  logic          sys_clk,
    input  logic          rst,
    input  logic          cap_en,
    input  logic [DW-1:0] cap_data,
    output logic          rvalid,
    output logic [DW-1:0] rdata
);
    logic          rvalid_d, rvalid_q;
    logic [DW-1:0] rdata_d,  rdata_q;

    // Next read-return state: valid only after a granted read, data otherwise held
    always_comb begin
        rvalid_d = cap_en;
        if (cap_en) begin
            rdata_d = cap_data;
        end else begin
            rdata_d = rdata_q;
        end
    end

    // Read-return registers
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
        end
    end

    assign rvalid = rvalid_q;
    assign rdata  = rdata_q;
endmodule

// File: rtl/uart_ram_arbiter.sv
// Round-robin, burst-bounded arbiter sharing one async-read single-port RAM
// between the UART command engine (m0) and a second master (m1).
// Grants are combinational from the registered owner; read data returns one cycle later.
module uart_ram_arbiter
    import uart_ram_arbiter_pkg::*;
#(
    parameter int AW        = 8,
    parameter int DW        = 8,
    parameter int MAX_BURST = DEF_MAX_BURST
) (
    input  logic                sys_clk,
    input  logic                rst,
    uart_ram_arbiter_if.slave   m0,
    uart_ram_arbiter_if.slave   m1,
    output logic                ram_we,
    output logic [AW-1:0]       ram_addr,
    output logic [DW-1:0]       ram_din,
    input  logic [DW-1:0]       ram_dout
);
    localparam int             CW         = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0]  BURST_LAST = CW'(MAX_BURST - 1);

    logic [1:0]    owner_d, owner_q;
    logic          last_d,  last_q;
    logic [CW-1:0] cnt_d,   cnt_q;

    logic gnt0_s, gnt1_s;
    logic cur_idx_s, cur_req_s, oth_req_s;

    assign gnt0_s    = (owner_q == ARB_OWN0) & m0.req;
    assign gnt1_s    = (owner_q == ARB_OWN1) & m1.req;
    assign cur_idx_s = (owner_q == ARB_OWN1);
    assign cur_req_s = cur_idx_s ? m1.req : m0.req;
    assign oth_req_s = cur_idx_s ? m0.req : m1.req;

    assign m0.gnt = gnt0_s;
    assign m1.gnt = gnt1_s;

    // Ownership FSM: IDLE picks by round-robin, owners keep the RAM up to the burst window
    always_comb begin
        owner_d = owner_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        case (owner_q)
            ARB_IDLE: begin
                cnt_d = '0;
                if (m0.req && m1.req) begin
                    owner_d = arb_own_of(~last_q);
                end else if (m0.req) begin
                    owner_d = ARB_OWN0;
                end else if (m1.req) begin
                    owner_d = ARB_OWN1;
                end else begin
                    owner_d = ARB_IDLE;
                end
            end
            ARB_OWN0, ARB_OWN1: begin
                if (cur_req_s) begin
                    if (cnt_q == BURST_LAST) begin
                        // window exhausted: hand over without a bubble, or open a new window
                        cnt_d = '0;
                        if (oth_req_s) begin
                            owner_d = arb_own_of(~cur_idx_s);
                            last_d  = cur_idx_s;
                        end else begin
                            owner_d = owner_q;
                            last_d  = last_q;
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end else begin
                    // voluntary release: the dropped-req cycle is the switch bubble
                    cnt_d  = '0;
                    last_d = cur_idx_s;
                    if (oth_req_s) begin
                        owner_d = arb_own_of(~cur_idx_s);
                    end else begin
                        owner_d = ARB_IDLE;
                    end
                end
            end
            default: begin
                owner_d = ARB_IDLE;
                last_d  = last_q;
                cnt_d   = '0;
            end
        endcase
    end

    // Arbiter state registers; last=1 so m0 wins the first tie
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            owner_q <= ARB_IDLE;
            last_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    // RAM drive: owner's address/data, write strobe only on a granted write
    always_comb begin
        ram_we = (gnt0_s & m0.we) | (gnt1_s & m1.we);
        case (owner_q)
            ARB_OWN0: begin
                ram_addr = m0.addr;
                ram_din  = m0.wdata;
            end
            ARB_OWN1: begin
                ram_addr = m1.addr;
                ram_din  = m1.wdata;
            end
            default: begin
                ram_addr = '0;
                ram_din  = '0;
            end
        endcase
    end

    uart_ram_arbiter_rd_capture #(.DW(DW)) u_cap0 (
        .sys_clk  (sys_clk),
        .rst      (rst),
        .cap_en   (gnt0_s & ~m0.we),
        .cap_data (ram_dout),
        .rvalid   (m0.rvalid),
        .rdata    (m0.rdata)
    );

    uart_ram_arbiter_rd_capture #(.DW(DW)) u_cap1 (
        .sys_clk  (sys_clk),
        .rst      (rst),
        .cap_en   (gnt1_s & ~m1.we),
        .cap_data (ram_dout),
        .rvalid   (m1.rvalid),
        .rdata    (m1.rdata)
    );
endmodule

// File: tb/tb_uart_ram_arbiter.sv
// Self-checking bench for uart_ram_arbiter: directed scenarios with literal
// expectations, then randomized traffic against a behavioural arbiter/RAM model.
module tb_uart_ram_arbiter;
    localparam int MAXB = 4;

    logic       sys_clk = 1'b0;
    logic       rst     = 1'b1;
    logic       ram_we;
    logic [7:0] ram_addr, ram_din, ram_dout;

    logic       req_v   [2];
    logic       we_v    [2];
    logic [7:0] addr_v  [2];
    logic [7:0] wdata_v [2];

    logic [7:0] ram_mem [256];
    logic [7:0] ref_mem [256];

    int errors = 0;
    int checks = 0;

    // behavioural model: who owns the RAM (-1 none), who was served last, accesses in window
    int   own, last, served;
    bit   e_rv [2];
    logic [7:0] e_rd [2];
    bit   mg [2];
    int   gq [$];

    uart_ram_arbiter_if #(.AW(8), .DW(8)) m0_if ();
    uart_ram_arbiter_if #(.AW(8), .DW(8)) m1_if ();

    assign m0_if.req = req_v[0];  assign m0_if.we = we_v[0];
    assign m0_if.addr = addr_v[0]; assign m0_if.wdata = wdata_v[0];
    assign m1_if.req = req_v[1];  assign m1_if.we = we_v[1];
    assign m1_if.addr = addr_v[1]; assign m1_if.wdata = wdata_v[1];

    uart_ram_arbiter #(.AW(8), .DW(8), .MAX_BURST(MAXB)) dut (
        .sys_clk  (sys_clk),
        .rst      (rst),
        .m0       (m0_if),
        .m1       (m1_if),
        .ram_we   (ram_we),
        .ram_addr (ram_addr),
        .ram_din  (ram_din),
        .ram_dout (ram_dout)
    );

    always #5 sys_clk = ~sys_clk;

    // dmg_ram stand-in: async read, write on rising edge
    assign ram_dout = ram_mem[ram_addr];
    always @(posedge sys_clk) begin
        if (ram_we) ram_mem[ram_addr] <= ram_din;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        own = -1; last = 1; served = 0;
        e_rv[0] = 0; e_rv[1] = 0;
        e_rd[0] = 8'h00; e_rd[1] = 8'h00;
        mg[0] = 0; mg[1] = 0;
    endtask

    // compare every DUT output with the model for the current cycle
    task automatic check_outputs();
        bit eg [2];
        logic [7:0] ea, ed;
        bit ewe;
        if (rst) model_reset();
        for (int i = 0; i < 2; i++) eg[i] = (own == i) && req_v[i];
        ewe = (eg[0] && we_v[0]) || (eg[1] && we_v[1]);
        ea = (own >= 0) ? addr_v[own]  : 8'h00;
        ed = (own >= 0) ? wdata_v[own] : 8'h00;
        chk("m0_gnt",    {31'd0, m0_if.gnt},    {31'd0, eg[0]});
        chk("m1_gnt",    {31'd0, m1_if.gnt},    {31'd0, eg[1]});
        chk("ram_we",    {31'd0, ram_we},       {31'd0, ewe});
        chk("ram_addr",  {24'd0, ram_addr},     {24'd0, ea});
        chk("ram_din",   {24'd0, ram_din},      {24'd0, ed});
        chk("m0_rvalid", {31'd0, m0_if.rvalid}, {31'd0, e_rv[0]});
        chk("m1_rvalid", {31'd0, m1_if.rvalid}, {31'd0, e_rv[1]});
        chk("m0_rdata",  {24'd0, m0_if.rdata},  {24'd0, e_rd[0]});
        chk("m1_rdata",  {24'd0, m1_if.rdata},  {24'd0, e_rd[1]});
        gq.push_back(m0_if.gnt ? 0 : (m1_if.gnt ? 1 : -1));
    endtask

    // advance the model across one rising edge using the inputs held during the cycle
    task automatic model_edge();
        bit g [2];
        int o;
        if (rst) begin
            model_reset();
            return;
        end
        for (int i = 0; i < 2; i++) g[i] = (own == i) && req_v[i];
        for (int i = 0; i < 2; i++) begin
            e_rv[i] = g[i] && !we_v[i];
            if (e_rv[i]) e_rd[i] = ref_mem[addr_v[i]];
        end
        for (int i = 0; i < 2; i++) if (g[i] && we_v[i]) ref_mem[addr_v[i]] = wdata_v[i];
        mg[0] = g[0]; mg[1] = g[1];
        if (own < 0) begin
            served = 0;
            if (req_v[0] && req_v[1]) own = 1 - last;
            else if (req_v[0])        own = 0;
            else if (req_v[1])        own = 1;
        end else begin
            o = 1 - own;
            if (req_v[own]) begin
                served = served + 1;
                if (served == MAXB) begin
                    served = 0;
                    if (req_v[o]) begin last = own; own = o; end
                end
            end else begin
                served = 0;
                last = own;
                own = req_v[o] ? o : -1;
            end
        end
    endtask

    // one clock: check at mid-low phase, model the edge, return at the next falling edge
    task automatic tick();
        #1;
        check_outputs();
        @(posedge sys_clk);
        model_edge();
        @(negedge sys_clk);
    endtask

    task automatic set_m(input int i, input logic r, input logic w, input logic [7:0] a, input logic [7:0] d);
        req_v[i] = r; we_v[i] = w; addr_v[i] = a; wdata_v[i] = d;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_m(0, 1'b0, 1'b0, 8'h00, 8'h00);
        set_m(1, 1'b0, 1'b0, 8'h00, 8'h00);
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int exp4 [9];
        int n5;
        for (int a = 0; a < 256; a++) begin ram_mem[a] = 8'h00; ref_mem[a] = 8'h00; end
        model_reset();
        exp4 = '{-1, 1, 1, -1, 0, 0, 0, 0, 1};

        // 1/2: writes blocked in reset, then m0 write 0x3C -> 0x10 and read back
        set_m(0, 1'b1, 1'b1, 8'h10, 8'h3C);
        set_m(1, 1'b0, 1'b0, 8'h00, 8'h00);
        @(negedge sys_clk);
        #1 chk("t1_ram_we_in_rst", {31'd0, ram_we}, 32'd0);
        chk("t1_gnt_in_rst", {31'd0, m0_if.gnt}, 32'd0);
        tick(); tick();
        rst = 1'b0;
        #1 chk("t1_no_gnt_first_cycle", {31'd0, m0_if.gnt}, 32'd0);
        tick();
        #1 chk("t1_gnt_cycle2", {31'd0, m0_if.gnt}, 32'd1);
        chk("t1_ram_we_cycle2", {31'd0, ram_we}, 32'd1);
        chk("t1_ram_addr", {24'd0, ram_addr}, 32'h10);
        tick();
        we_v[0] = 1'b0;
        #1 chk("t2_read_gnt", {31'd0, m0_if.gnt}, 32'd1);
        chk("t2_read_no_we", {31'd0, ram_we}, 32'd0);
        tick();
        req_v[0] = 1'b0;
        #1 chk("t2_rvalid", {31'd0, m0_if.rvalid}, 32'd1);
        chk("t2_rdata", {24'd0, m0_if.rdata}, 32'h3C);
        tick();

        // 3: both request continuously -> 0x4, 1x4, 0x4, 1x4 with no idle between owners
        do_reset();
        set_m(0, 1'b1, 1'b0, 8'h10, 8'h00);
        set_m(1, 1'b1, 1'b0, 8'h11, 8'h00);
        gq.delete();
        repeat (17) tick();
        for (int k = 0; k < 17; k++)
            chk($sformatf("t3_grant_%0d", k), gq[k], (k == 0) ? -1 : (((k - 1) / 4) % 2));

        // 4: m1 releases after two accesses while m0 waits -> one bubble, m0 gets a full window
        do_reset();
        set_m(1, 1'b1, 1'b0, 8'h05, 8'h00);
        gq.delete();
        tick();
        set_m(0, 1'b1, 1'b0, 8'h06, 8'h00);
        tick(); tick();
        req_v[1] = 1'b0;
        tick();
        req_v[1] = 1'b1;
        repeat (5) tick();
        for (int k = 0; k < 9; k++)
            chk($sformatf("t4_grant_%0d", k), gq[k], exp4[k]);

        // 5: m0 alone for 10 accesses -> granted every cycle, no switch at window edges
        do_reset();
        gq.delete();
        set_m(0, 1'b1, 1'b1, 8'h40, 8'h80);
        tick();
        for (int k = 0; k < 10; k++) begin
            set_m(0, 1'b1, 1'b1, 8'h40 + 8'(k), 8'h80 + 8'(k));
            tick();
        end
        n5 = 0;
        for (int k = 1; k < 11; k++) if (gq[k] == 0) n5++;
        chk("t5_idle_first", gq[0], -1);
        chk("t5_grant_count", n5, 10);

        // 6: reset mid-burst during an m1 write to 0x20 drops the write
        do_reset();
        set_m(0, 1'b1, 1'b1, 8'h20, 8'h55);
        tick(); tick();
        set_m(0, 1'b0, 1'b0, 8'h00, 8'h00);
        set_m(1, 1'b1, 1'b1, 8'h21, 8'h01);
        tick(); tick();
        set_m(1, 1'b1, 1'b1, 8'h20, 8'hAA);
        #1 chk("t6_m1_gnt_before_rst", {31'd0, m1_if.gnt}, 32'd1);
        chk("t6_ram_we_before_rst", {31'd0, ram_we}, 32'd1);
        #1 rst = 1'b1;
        #1 chk("t6_ram_we_drops", {31'd0, ram_we}, 32'd0);
        chk("t6_m1_gnt_drops", {31'd0, m1_if.gnt}, 32'd0);
        chk("t6_m1_rvalid_rst", {31'd0, m1_if.rvalid}, 32'd0);
        tick();
        rst = 1'b0;
        set_m(1, 1'b0, 1'b0, 8'h00, 8'h00);
        set_m(0, 1'b1, 1'b0, 8'h20, 8'h00);
        tick();
        #1 chk("t6_read_gnt", {31'd0, m0_if.gnt}, 32'd1);
        tick();
        req_v[0] = 1'b0;
        #1 chk("t6_rvalid", {31'd0, m0_if.rvalid}, 32'd1);
        chk("t6_prior_contents", {24'd0, m0_if.rdata}, 32'h55);
        tick();

        // randomized traffic: a pending request is held until granted, then re-drawn
        mg[0] = 1; mg[1] = 1;
        for (int c = 0; c < 2000; c++) begin
            rst = ($urandom_range(0, 299) == 0);
            for (int i = 0; i < 2; i++) begin
                if (!req_v[i] || mg[i])
                    set_m(i, ($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)),
                          8'($urandom_range(0, 15)), 8'($urandom));
            end
            tick();
        end
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
